// File: rtl/disp_pkg.sv
// Display geometry shared by the memory, the row scanner and the row driver,
// plus the scanner state encoding and the {row, col} address helper.
package disp_pkg;

   localparam int ROWS   = 32;
   localparam int COLS   = 32;
   localparam int ADDR_W = 10;
   localparam int ROW_W  = $clog2(ROWS);
   localparam int COL_W  = $clog2(COLS);
   localparam int DEPTH  = 1 << ADDR_W;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DRAIN,
      PRESENT,
      DONE
   } scan_state_t;

   // Row and column fields are concatenated; any spare upper address bits stay zero.
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [ROW_W-1:0] r,
                                                 input logic [COL_W-1:0] c);
      logic [ADDR_W-1:0] a;
      a = '0;
      a[ROW_W+COL_W-1:0] = {r, c};
      return a;
   endfunction

endpackage

// File: rtl/disp_row_scanner_if.sv
// Packed-row handshake between the row scanner (master) and the LED row driver (slave).
interface disp_row_scanner_if;
   import disp_pkg::*;

   logic [COLS-1:0]  row_data;
   logic [ROW_W-1:0] row_idx;
   logic             row_valid;
   logic             row_ready;

   modport master (
      output row_data,
      output row_idx,
      output row_valid,
      input  row_ready
   );

   modport slave (
      input  row_data,
      input  row_idx,
      input  row_valid,
      output row_ready
   );

endinterface

// File: rtl/mem_disp.sv
// 1 x DEPTH display bit memory: one write port, one read port with a registered
// output, so read data appears the cycle after its address.
module mem_disp
   import disp_pkg::*;
(
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_d,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              d_o
);

   logic mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_d;
      end
      d_o <= mem[rd_addr];
   end

endmodule

// File: rtl/disp_row_scanner.sv
// Sweeps the display memory row by row, packs each row into one word and offers it
// on a valid/ready handshake; COLS+2 cycles per row when unstalled, fetch halts while a row waits.
module disp_row_scanner
   import disp_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   output logic                      busy,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic                      mem_d,
   disp_row_scanner_if.master        rbus,
   output logic                      frame_done
);

   scan_state_t      state;
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;
   logic [COLS-1:0]  shreg;
   logic             valid;

   assign rbus.row_data  = shreg;
   assign rbus.row_idx   = row;
   assign rbus.row_valid = valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         mem_addr   <= '0;
         row        <= '0;
         col        <= '0;
         shreg      <= '0;
         valid      <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               frame_done <= 1'b0;
               if (start) begin
                  state    <= FETCH;
                  busy     <= 1'b1;
                  row      <= '0;
                  col      <= '0;
                  mem_addr <= '0;
               end
            end

            FETCH: begin
               // Read data lags its address by one cycle, so this edge lands column col-1.
               if (col != '0) begin
                  shreg[col - 1'b1] <= mem_d;
               end
               if (col == COL_W'(COLS - 1)) begin
                  state <= DRAIN;
               end else begin
                  col      <= col + 1'b1;
                  mem_addr <= pix_addr(row, col + 1'b1);
               end
            end

            DRAIN: begin
               shreg[COLS-1] <= mem_d;
               valid         <= 1'b1;
               state         <= PRESENT;
            end

            PRESENT: begin
               if (rbus.row_ready) begin
                  valid <= 1'b0;
                  if (row == ROW_W'(ROWS - 1)) begin
                     state      <= DONE;
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                     mem_addr   <= '0;
                  end else begin
                     state    <= FETCH;
                     row      <= row + 1'b1;
                     col      <= '0;
                     mem_addr <= pix_addr(row + 1'b1, '0);
                  end
               end
            end

            DONE: begin
               frame_done <= 1'b0;
               state      <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
